// File: rtl/med_pkg.sv
// Shared types and constants for the MED median sequencer and its datapath.
package med_pkg;

  localparam int N_DEFAULT = 9;
  localparam int DW        = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT_LO,
    SORT_HI,
    DRAIN,
    OUT
  } med_state_t;

  // Cycles from the first DSI cycle of a burst to the DSO pulse.
  function automatic int med_lat(input int n);
    return n + ((n - 1) / 2) * n + (n - 1) / 2;
  endfunction

endpackage

// File: rtl/med_ctrl_if.sv
// Pixel/strobe bus between the pixel source and med_ctrl.
// ERR exists only when MED_CTRL_ERR_EN is defined.
interface med_ctrl_if import med_pkg::*; ();

  logic          dsi;
  logic [DW-1:0] di;
  logic          ready;
  logic          byp;
  logic          mdsi;
  logic          dso;
  logic [DW-1:0] dout;
`ifdef MED_CTRL_ERR_EN
  logic          err;
`endif

  modport master (
    output dsi, di,
    input  ready, byp, mdsi, dso, dout
`ifdef MED_CTRL_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  dsi, di,
    output ready, byp, mdsi, dso, dout
`ifdef MED_CTRL_ERR_EN
    , output err
`endif
  );

endinterface

// File: rtl/med.sv
// MED median operator: N-register chain with a compare/exchange element at its tail.
module med import med_pkg::*; #(
  parameter int N = N_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dsi,
  input  logic          byp,
  input  logic [DW-1:0] di,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] r [N];
  logic [DW-1:0] mx;
  logic [DW-1:0] mn;

  assign mx = (r[N-2] > r[N-1]) ? r[N-2] : r[N-1];
  assign mn = (r[N-2] > r[N-1]) ? r[N-1] : r[N-2];

  // Tail keeps the running maximum while the smaller value recirculates to the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else begin
      for (int i = 1; i < N - 1; i++) r[i] <= r[i-1];
      r[0]   <= dsi ? di : mn;
      r[N-1] <= byp ? r[N-2] : mx;
    end
  end

  assign dout = r[N-1];

endmodule

// File: rtl/med_seq_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero (last cycle of a phase).
module med_seq_cnt import med_pkg::*; #(
  parameter int W = $clog2(N_DEFAULT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/med_ctrl.sv
// Burst sequencer driving MED through load, partial-sort passes and drain.
// Optional ERR output and error detection enabled by defining MED_CTRL_ERR_EN.
module med_ctrl import med_pkg::*; #(
  parameter int N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  med_ctrl_if.slave  bus
);

  localparam int R  = (N - 1) / 2;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(R + 1);

  med_state_t    state, state_n;
  logic [CW-1:0] lcnt, lcnt_n;
  logic [PW-1:0] pass, pass_n;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_tc;
  logic          byp_c;
  logic          dso_c;
  logic          byp_o;
  logic [DW-1:0] med_do;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lcnt  <= '0;
      pass  <= '0;
    end else begin
      state <= state_n;
      lcnt  <= lcnt_n;
      pass  <= pass_n;
    end
  end

  // Phase counter is loaded with (length - 1) on the transition into each timed phase.
  always_comb begin
    state_n  = state;
    lcnt_n   = lcnt;
    pass_n   = pass;
    cnt_load = 1'b0;
    cnt_val  = '0;
    byp_c    = 1'b0;
    dso_c    = 1'b0;
    case (state)
      IDLE: begin
        byp_c = bus.dsi;
        if (bus.dsi) begin
          state_n = LOAD;
          lcnt_n  = CW'(1);
        end
      end
      LOAD: begin
        byp_c = bus.dsi;
        if (!bus.dsi) begin
          state_n = IDLE;
          lcnt_n  = '0;
        end else if (lcnt == CW'(N - 1)) begin
          state_n  = SORT_LO;
          lcnt_n   = '0;
          pass_n   = '0;
          cnt_load = 1'b1;
          cnt_val  = CW'(N - 2);
        end else begin
          lcnt_n = lcnt + CW'(1);
        end
      end
      SORT_LO: begin
        if (cnt_tc) begin
          state_n  = SORT_HI;
          cnt_load = 1'b1;
          cnt_val  = CW'(pass);
        end
      end
      SORT_HI: begin
        byp_c = 1'b1;
        if (cnt_tc) begin
          cnt_load = 1'b1;
          if (pass < PW'(R - 1)) begin
            state_n = SORT_LO;
            pass_n  = pass + PW'(1);
            cnt_val = CW'(N - 3) - CW'(pass);
          end else begin
            state_n = DRAIN;
            cnt_val = CW'(R - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_tc) state_n = OUT;
      end
      OUT: begin
        dso_c   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  med_seq_cnt #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .val  (cnt_val),
    .tc   (cnt_tc)
  );

  // Outputs are forced quiet combinationally so reset takes effect in the same cycle.
  assign byp_o     = byp_c & ~rst;
  assign bus.byp   = byp_o;
  assign bus.mdsi  = byp_o;
  assign bus.dso   = dso_c & ~rst;
  assign bus.ready = (state == IDLE) & ~rst;
  assign bus.dout  = med_do;

`ifdef MED_CTRL_ERR_EN
  logic dsi_q;
  logic short_burst;
  logic spurious;

  always_ff @(posedge clk) begin
    if (rst) dsi_q <= 1'b0;
    else     dsi_q <= bus.dsi;
  end

  assign short_burst = (state == LOAD) & ~bus.dsi;
  assign spurious    = bus.dsi & ~dsi_q & (state != IDLE) & (state != LOAD);
  assign bus.err     = (short_burst | spurious) & ~rst;
`endif

  med #(.N(N)) u_med (
    .clk  (clk),
    .rst  (rst),
    .dsi  (byp_o),
    .byp  (byp_o),
    .di   (bus.di),
    .dout (med_do)
  );

endmodule
